// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (IF) and load/store (DM) requesters.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned DM_MAX_CONSEC  = 4,
   parameter logic [2:0]  DMT_WORD       = 3'b000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [2:0]  dm_dmtype,
   output logic        dm_ack,
   output logic [31:0] dm_rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_dmtype,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall_if,
   output logic        stall_mem,
   output logic [1:0]  dbg_state
);

   // Handshake: a requester raises req with its payload and holds both until its ack pulses
   // for one cycle; the req seen during that ack cycle is the old one and is not granted again.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_IF_BUSY = 2'd1,
      S_DM_BUSY = 2'd2
   } state_t;

   localparam logic [2:0] LP_MAX_CONSEC = 3'(DM_MAX_CONSEC);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_consec;
   logic        r_if_ack;
   logic        r_dm_ack;
   logic        r_err;
   logic [31:0] r_if_rdata;
   logic [31:0] r_dm_rdata;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [2:0]  r_mem_dmtype;

   logic        w_any_ack;
   logic        w_if_elig;
   logic        w_dm_elig;
   logic        w_grant_if;
   logic        w_grant_dm;
   logic        w_done;
   logic        w_abort;
   logic        w_tmo_hit;

   // No grant is made while any ack pulses: the acked req is stale, and handing the bus to the
   // other side in that cycle would break every DM burst and make the fairness limit meaningless.
   assign w_any_ack = r_if_ack | r_dm_ack;
   assign w_if_elig = if_req & ~w_any_ack;
   assign w_dm_elig = dm_req & ~w_any_ack;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned        LP_TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [LP_TW-1:0]   LP_TMO_LAST = LP_TW'(TIMEOUT_CYCLES - 1);
   logic [LP_TW-1:0] r_tmo;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmo <= '0;
      end else if (r_state == S_IDLE) begin
         r_tmo <= '0;
      end else if (!mem_ready) begin
         r_tmo <= r_tmo + 1'b1;
      end
   end

   // The edge that would bring the count to TIMEOUT_CYCLES performs the abort.
   assign w_tmo_hit = (r_tmo == LP_TMO_LAST);
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
   assign w_tmo_hit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_if  = 1'b0;
      w_grant_dm  = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_dm_elig && ((r_consec < LP_MAX_CONSEC) || !w_if_elig)) begin
               w_grant_dm  = 1'b1;
               w_state_nxt = S_DM_BUSY;
            end else if (w_if_elig) begin
               w_grant_if  = 1'b1;
               w_state_nxt = S_IF_BUSY;
            end
         end
         S_IF_BUSY, S_DM_BUSY: begin
            if (mem_ready) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_tmo_hit) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_consec     <= '0;
         r_if_ack     <= 1'b0;
         r_dm_ack     <= 1'b0;
         r_err        <= 1'b0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_dmtype <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         r_err    <= 1'b0;
         if (w_grant_dm) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= dm_we;
            r_mem_addr   <= dm_addr;
            r_mem_wdata  <= dm_wdata;
            r_mem_dmtype <= dm_dmtype;
            if (!if_req) begin
               r_consec <= '0;
            end else if (r_consec < LP_MAX_CONSEC) begin
               r_consec <= r_consec + 1'b1;
            end
         end else if (w_grant_if) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_mem_wdata  <= '0;
            r_mem_dmtype <= DMT_WORD;
            r_consec     <= '0;
         end else if (w_done || w_abort) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_err     <= w_abort;
            if (r_state == S_IF_BUSY) begin
               r_if_ack   <= 1'b1;
               r_if_rdata <= w_done ? mem_rdata : 32'h0;
            end else begin
               r_dm_ack   <= 1'b1;
               r_dm_rdata <= w_done ? mem_rdata : 32'h0;
            end
         end
      end
   end

   assign if_ack     = r_if_ack;
   assign dm_ack     = r_dm_ack;
   assign err        = r_err;
   assign if_rdata   = r_if_rdata;
   assign dm_rdata   = r_dm_rdata;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_dmtype = r_mem_dmtype;
   assign stall_if   = if_req & ~r_if_ack;
   assign stall_mem  = dm_req & ~r_dm_ack;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/fetch contention, DM burst limit,
// asynchronous reset mid-access and the BUSY watchdog (or its absence).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [2:0]  dm_dmtype = '0;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_dmtype;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        stall_if;
   logic        stall_mem;
   logic [1:0]  dbg_state;

   int n_assert = 0;
   int n_fail   = 0;

   mem_port_arbiter #(
      .DM_MAX_CONSEC (4),
      .DMT_WORD      (3'b000),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_dmtype (dm_dmtype),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_dmtype(mem_dmtype),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full access from the idle bus: grant edge, ready edge, then the ack (dead) cycle.
   task automatic access(input string tag, input logic exp_dm, input logic [31:0] exp_addr,
                         input logic exp_we, input logic [31:0] exp_wdata,
                         input logic [2:0] exp_dmtype, input logic [31:0] rdata);
      tick();
      chk({tag, "_state"}, 32'(dbg_state), exp_dm ? 32'd2 : 32'd1);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_mem_addr"}, mem_addr, exp_addr);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'(exp_we));
      chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
      chk({tag, "_mem_dmtype"}, 32'(mem_dmtype), 32'(exp_dmtype));
      mem_ready = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      chk({tag, "_if_ack"}, 32'(if_ack), exp_dm ? 32'd0 : 32'd1);
      chk({tag, "_dm_ack"}, 32'(dm_ack), exp_dm ? 32'd1 : 32'd0);
      chk({tag, "_rdata"}, exp_dm ? dm_rdata : if_rdata, rdata);
      chk({tag, "_stall_off"}, 32'(exp_dm ? stall_mem : stall_if), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_req_clr"}, {30'd0, mem_req, mem_we}, 32'd0);
      tick();
      chk({tag, "_dead"}, {29'd0, if_ack, dm_ack, mem_req}, 32'd0);
   endtask

   initial begin
      int  k;
      logic seen;

      // Reset
      tick();
      chk("rst_mem", {28'd0, mem_req, mem_we, if_ack, dm_ack}, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
      rst = 1'b1;

      // mem_ready in IDLE is ignored
      mem_ready = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      tick();
      chk("idle_ready", {29'd0, if_ack, dm_ack, mem_req}, 32'd0);
      chk("idle_ready_rdata", if_rdata | dm_rdata, 32'd0);
      mem_ready = 1'b0;

      // T1: single fetch, ack two cycles after request
      if_req  = 1'b1;
      if_addr = 32'h0000_0004;
      #1;
      chk("t1_stall_if", 32'(stall_if), 32'd1);
      access("t1", 1'b0, 32'h4, 1'b0, 32'h0, 3'b000, 32'h0010_0093);
      if_req = 1'b0;
      tick();
      chk("t1_rdata_hold", if_rdata, 32'h0010_0093);

      // T2: simultaneous store and fetch, DM wins
      if_req    = 1'b1;
      if_addr   = 32'h0000_0008;
      dm_req    = 1'b1;
      dm_we     = 1'b1;
      dm_addr   = 32'h0000_0100;
      dm_wdata  = 32'hDEAD_BEEF;
      dm_dmtype = 3'b010;
      #1;
      chk("t2_stall_mem", 32'(stall_mem), 32'd1);
      access("t2_dm", 1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF, 3'b010, 32'h1111_2222);
      dm_req = 1'b0;
      access("t2_if", 1'b0, 32'h8, 1'b0, 32'h0, 3'b000, 32'h0020_0113);
      if_req = 1'b0;

      // T3: DM held for 6 loads with IF waiting; limit 4 gives DM,DM,DM,DM,IF,DM,DM
      dm_req    = 1'b1;
      dm_we     = 1'b0;
      dm_addr   = 32'h0000_0200;
      dm_wdata  = 32'h0;
      dm_dmtype = 3'b010;
      if_req    = 1'b1;
      if_addr   = 32'h0000_000C;
      access("t3_dm1", 1'b1, 32'h200, 1'b0, 32'h0, 3'b010, 32'hA000_0001);
      chk("t3_stall_if1", 32'(stall_if), 32'd1);
      access("t3_dm2", 1'b1, 32'h200, 1'b0, 32'h0, 3'b010, 32'hA000_0002);
      access("t3_dm3", 1'b1, 32'h200, 1'b0, 32'h0, 3'b010, 32'hA000_0003);
      access("t3_dm4", 1'b1, 32'h200, 1'b0, 32'h0, 3'b010, 32'hA000_0004);
      chk("t3_stall_if4", 32'(stall_if), 32'd1);
      access("t3_if", 1'b0, 32'hC, 1'b0, 32'h0, 3'b000, 32'hB000_0005);
      if_req = 1'b0;
      access("t3_dm5", 1'b1, 32'h200, 1'b0, 32'h0, 3'b010, 32'hA000_0006);
      access("t3_dm6", 1'b1, 32'h200, 1'b0, 32'h0, 3'b010, 32'hA000_0007);
      dm_req = 1'b0;
      chk("t3_if_rdata_hold", if_rdata, 32'hB000_0005);

      // T4: reset during a stalled load
      dm_req  = 1'b1;
      dm_addr = 32'h0000_0300;
      tick();
      chk("t4_grant", 32'(dbg_state), 32'd2);
      tick();
      tick();
      tick();
      chk("t4_wait", {30'd0, mem_req, dm_ack}, 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("t4_async_req", 32'(mem_req), 32'd0);
      chk("t4_async_state", 32'(dbg_state), 32'd0);
      tick();
      dm_req = 1'b0;
      rst    = 1'b1;
      tick();
      chk("t4_no_ack", {30'd0, dm_ack, mem_req}, 32'd0);
      chk("t4_state", 32'(dbg_state), 32'd0);
      chk("t4_rdata_clr", dm_rdata, 32'd0);

      // Load a non-zero value so the abort's zero rdata is observable
      dm_req  = 1'b1;
      dm_addr = 32'h0000_0400;
      access("t5_pre", 1'b1, 32'h400, 1'b0, 32'h0, 3'b010, 32'hCAFE_F00D);

      // T5: memory never answers
      tick();
      chk("t5_grant", 32'(dbg_state), 32'd2);
      k    = 0;
      seen = 1'b0;
      for (int i = 1; i <= 100 && !seen; i++) begin
         tick();
         if (dm_ack) begin
            seen = 1'b1;
            k    = i;
         end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      chk("t5_ack_seen", 32'(seen), 32'd1);
      chk("t5_ack_cycle", 32'(k), 32'd8);
      chk("t5_err", 32'(err), 32'd1);
      chk("t5_rdata_zero", dm_rdata, 32'd0);
      chk("t5_idle", {29'd0, dbg_state, mem_req}, 32'd0);
      dm_req = 1'b0;
      tick();
      chk("t5_err_pulse", 32'(err), 32'd0);
`else
      chk("t5_no_ack", 32'(seen), 32'd0);
      chk("t5_still_busy", {29'd0, dbg_state, mem_req}, 32'd5);
      chk("t5_no_err", 32'(err), 32'd0);
      chk("t5_rdata_hold", dm_rdata, 32'hCAFE_F00D);
      dm_req = 1'b0;
      rst    = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("t5_reset_idle", {29'd0, dbg_state, mem_req}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
